// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async FIFO
// write-side arbiter.
package async_fifo_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write port
// bundle seen by the write-side arbiter.
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATAWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wfull;
  logic                         winc;
  logic [DATAWIDTH-1:0]         wdata;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    input  req_ready,
    output wfull,
    input  winc,
    input  wdata
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    output req_ready,
    input  wfull,
    output winc,
    output wdata
  );

endinterface

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set
// request strictly after last, wrapping.
module rr_pick
  import async_fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Walk down so the lowest position in the
  // window (last, last+N] wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 2*N-1; k >= 0; k--) begin
      if (dbl[k] &&
          (k > int'(last)) &&
          (k <= int'(last) + N)) begin
        found = 1'b1;
        idx   = IW'(k % N);
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin scheduler sharing one async FIFO
// write port among NUM_REQ write-domain requesters.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int MAX_BURST = 8,
  localparam int IW = idx_w(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST+1)
) (
  input  logic                    wclk,
  input  logic                    wrst,
  async_fifo_wr_arbiter_if.slave  bus,
  output logic                    grant_active,
  output logic [IW-1:0]           grant_id
);

  arb_state_t        state;
  logic [IW-1:0]     last_grant;
  logic [BW-1:0]     beat_cnt;
  logic              found;
  logic [IW-1:0]     pick;
  logic              busy;
  logic              rel;
  logic [NUM_REQ-1:0] rdy;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .last  (last_grant),
    .found (found),
    .idx   (pick)
  );

  assign busy = (state == BUSY);

  always_comb begin
    rdy = '0;
    if (busy && !bus.wfull)
      rdy[grant_id] = 1'b1;
  end

  assign bus.req_ready = rdy;
  assign bus.winc  = busy && !bus.wfull &&
                     bus.req_valid[grant_id];
  assign bus.wdata =
    bus.req_data[grant_id*DATAWIDTH +: DATAWIDTH];

  assign rel = bus.winc &&
               (bus.req_last[grant_id] ||
                (beat_cnt == BW'(MAX_BURST-1)));

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state        <= IDLE;
      grant_active <= 1'b0;
      grant_id     <= '0;
      last_grant   <= IW'(NUM_REQ-1);
      beat_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            last_grant   <= grant_id;
            beat_cnt     <= '0;
            grant_active <= 1'b0;
            state        <= IDLE;
          end else if (bus.winc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_winc_full: assert property (
    @(posedge wclk) disable iff (wrst)
    bus.winc |-> !bus.wfull);

  a_one_ready: assert property (
    @(posedge wclk) disable iff (wrst)
    $onehot0(bus.req_ready));

  a_winc_hs: assert property (
    @(posedge wclk) disable iff (wrst)
    bus.winc == |(bus.req_valid & bus.req_ready));

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter with
// queue-driven requesters and a write log.
module tb_async_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic       wclk;
  logic       wrst;
  logic       grant_active;
  logic [1:0] grant_id;

  async_fifo_wr_arbiter_if #(
    .NUM_REQ   (N),
    .DATAWIDTH (DW)
  ) bus ();

  async_fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATAWIDTH (DW),
    .MAX_BURST (8)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] q [N][$];
  logic [7:0] wlog [$];
  int         wcyc [$];
  int         glog [$];
  int         gdrop [$];
  logic [N-1:0] stall;
  logic [N-1:0] fire;
  logic         ga_prev;
  int           cycn;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    logic [8:0]      hd;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        hd = q[i][0];
        v[i] = !stall[i];
        l[i] = hd[8];
        d[i*DW +: DW] = hd[7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  function automatic int wat(input int i);
    return (i < wlog.size()) ? int'(wlog[i]) : -1;
  endfunction

  function automatic int gat(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  function automatic int dat(input int i);
    return (i < gdrop.size()) ? gdrop[i] : -1;
  endfunction

  function automatic int qtot();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  always @(negedge wclk) begin
    fire = bus.req_valid & bus.req_ready;
    if (bus.winc) begin
      wlog.push_back(bus.wdata);
      wcyc.push_back(cycn);
    end
    if (grant_active && !ga_prev)
      glog.push_back(int'(grant_id));
    if (!grant_active && ga_prev)
      gdrop.push_back(wlog.size());
    ga_prev = grant_active;
  end

  always @(posedge wclk) begin
    cycn++;
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i] && q[i].size() > 0)
        void'(q[i].pop_front());
    fire = '0;
    drive();
  end

  task automatic cyc();
    @(posedge wclk);
    #3;
  endtask

  task automatic clr_logs();
    wlog.delete();
    wcyc.delete();
    glog.delete();
    gdrop.delete();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    repeat (2) cyc();
    wrst = 1'b0;
    clr_logs();
  endtask

  task automatic run_done(input string tag,
                          input int maxc);
    int n = 0;
    while ((qtot() > 0 || grant_active) &&
           n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    cycn     = 0;
    fire     = '0;
    ga_prev  = 1'b0;
    stall    = '0;
    bus.wfull = 1'b0;
    wrst     = 1'b1;
    drive();
    repeat (2) cyc();
    chk("rst_ga",   32'(grant_active), 0);
    chk("rst_gid",  32'(grant_id), 0);
    chk("rst_winc", 32'(bus.winc), 0);
    chk("rst_rdy",  32'(bus.req_ready), 0);
    wrst = 1'b0;
    clr_logs();

    // single requester, 3-word packet
    q[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
    drive();
    #1;
    chk("s1_idle_winc", 32'(bus.winc), 0);
    chk("s1_idle_rdy",  32'(bus.req_ready), 0);
    cyc();
    chk("s1_ga",    32'(grant_active), 1);
    chk("s1_gid",   32'(grant_id), 0);
    chk("s1_winc1", 32'(bus.winc), 1);
    chk("s1_wd1",   32'(bus.wdata), 32'hA1);
    chk("s1_rdy1",  32'(bus.req_ready), 32'h1);
    cyc();
    chk("s1_wd2",   32'(bus.wdata), 32'hA2);
    cyc();
    chk("s1_wd3",   32'(bus.wdata), 32'hA3);
    chk("s1_last",  32'(bus.req_last), 32'h1);
    cyc();
    chk("s1_rel_ga",   32'(grant_active), 0);
    chk("s1_rel_winc", 32'(bus.winc), 0);
    chk("s1_nw",  32'(wlog.size()), 3);
    chk("s1_w0",  32'(wat(0)), 32'hA1);
    chk("s1_w2",  32'(wat(2)), 32'hA3);

    // round robin, 1-word packets
    do_reset();
    q[0] = '{9'h110, 9'h150};
    q[1] = '{9'h111};
    q[2] = '{9'h112};
    q[3] = '{9'h113};
    drive();
    run_done("s2_drain", 100);
    chk("s2_g0", 32'(gat(0)), 0);
    chk("s2_g1", 32'(gat(1)), 1);
    chk("s2_g2", 32'(gat(2)), 2);
    chk("s2_g3", 32'(gat(3)), 3);
    chk("s2_g4", 32'(gat(4)), 0);
    chk("s2_nw", 32'(wlog.size()), 5);
    chk("s2_w3", 32'(wat(3)), 32'h13);
    chk("s2_w4", 32'(wat(4)), 32'h50);
    if (wcyc.size() == 5) begin
      chk("s2_gap", 32'(wcyc[1] - wcyc[0]), 2);
      chk("s2_span", 32'(wcyc[4] - wcyc[0]), 8);
    end else begin
      chk("s2_wcyc", 32'(wcyc.size()), 5);
    end

    // burst limit with competing requester
    do_reset();
    for (int i = 0; i < 20; i++)
      q[2].push_back({(i == 19), 8'(32'h20 + i)});
    drive();
    cyc();
    q[0] = '{9'h105};
    drive();
    run_done("s3_drain", 200);
    chk("s3_g0", 32'(gat(0)), 2);
    chk("s3_g1", 32'(gat(1)), 0);
    chk("s3_g2", 32'(gat(2)), 2);
    chk("s3_g3", 32'(gat(3)), 2);
    chk("s3_d0", 32'(dat(0)), 8);
    chk("s3_d1", 32'(dat(1)), 9);
    chk("s3_d2", 32'(dat(2)), 17);
    chk("s3_w7", 32'(wat(7)), 32'h27);
    chk("s3_w8", 32'(wat(8)), 32'h05);
    chk("s3_w20", 32'(wat(20)), 32'h33);
    chk("s3_nw", 32'(wlog.size()), 21);

    // backpressure mid-packet
    do_reset();
    for (int i = 0; i < 10; i++)
      q[1].push_back({(i == 9), 8'(32'h40 + i)});
    drive();
    cyc();
    cyc();
    cyc();
    bus.wfull = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("s4_winc", 32'(bus.winc), 0);
      chk("s4_rdy",  32'(bus.req_ready), 0);
      chk("s4_ga",   32'(grant_active), 1);
      cyc();
    end
    bus.wfull = 1'b0;
    run_done("s4_drain", 100);
    chk("s4_g0", 32'(gat(0)), 1);
    chk("s4_g1", 32'(gat(1)), 1);
    chk("s4_d0", 32'(dat(0)), 8);
    chk("s4_nw", 32'(wlog.size()), 10);
    chk("s4_w2", 32'(wat(2)), 32'h42);
    chk("s4_w7", 32'(wat(7)), 32'h47);
    chk("s4_w9", 32'(wat(9)), 32'h49);

    // grant hold while owner idles
    do_reset();
    q[3] = '{9'h060, 9'h061, 9'h062, 9'h163};
    drive();
    cyc();
    q[0] = '{9'h170};
    drive();
    cyc();
    stall[3] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("s5_winc", 32'(bus.winc), 0);
      chk("s5_gid",  32'(grant_id), 3);
      chk("s5_ga",   32'(grant_active), 1);
      cyc();
    end
    stall[3] = 1'b0;
    drive();
    run_done("s5_drain", 100);
    chk("s5_g0", 32'(gat(0)), 3);
    chk("s5_g1", 32'(gat(1)), 0);
    chk("s5_d0", 32'(dat(0)), 4);
    chk("s5_w3", 32'(wat(3)), 32'h63);
    chk("s5_w4", 32'(wat(4)), 32'h70);

    // async reset mid-packet
    do_reset();
    q[1] = '{9'h090, 9'h091, 9'h192};
    drive();
    cyc();
    for (int i = 0; i < 5; i++)
      q[0].push_back({(i == 4), 8'(32'h80 + i)});
    drive();
    cyc();
    chk("s6_pre_gid", 32'(grant_id), 1);
    wrst = 1'b1;
    #1;
    chk("s6_winc", 32'(bus.winc), 0);
    chk("s6_rdy",  32'(bus.req_ready), 0);
    chk("s6_ga",   32'(grant_active), 0);
    chk("s6_gid",  32'(grant_id), 0);
    cyc();
    wrst = 1'b0;
    clr_logs();
    cyc();
    chk("s6_ga2",  32'(grant_active), 1);
    chk("s6_gid2", 32'(grant_id), 0);
    run_done("s6_drain", 100);
    chk("s6_g1", 32'(gat(1)), 1);
    chk("s6_nw", 32'(wlog.size()), 7);
    chk("s6_w0", 32'(wat(0)), 32'h80);
    chk("s6_w5", 32'(wat(5)), 32'h91);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Write-side scheduler that shares one async FIFO write port among NUM_REQ requesters in the write clock domain.
- Grants the port round-robin, holds the grant for a packet or burst, and drives winc/wdata.
- Honours wfull from the FIFO write-pointer/full logic.
- Sits directly in front of the FIFO write port; one instance per shared FIFO.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATAWIDTH, 8: FIFO data word width.
- MAX_BURST, 8: maximum beats per grant before forced release (>=1).

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  reset, asynchronous assert, active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by valid.
- req_data  input  NUM_REQ*DATAWIDTH  packed requester data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_ready  output  NUM_REQ  per-requester accept; transfer when valid & ready.
- wfull  input  1  FIFO full flag, registered in wclk domain.
- winc  output  1  FIFO write enable.
- wdata  output  DATAWIDTH  FIFO write data.
- grant_active  output  1  a requester currently holds the port.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Clock and reset: one clock, wclk. wrst is asynchronous, active-high; all flops clear immediately on assert.
- Reset values:
  - State IDLE; grant_active 0; grant_id 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
  - beat_cnt 0; winc 0; req_ready all 0.
- IDLE state:
  - If any req_valid is set, choose the first set bit searching upward, cyclically, from last_grant+1.
  - Register the choice in grant_id, set grant_active, and go to BUSY.
  - No transfer happens in IDLE, so there is one cycle of arbitration latency.
- BUSY state, combinational outputs for granted index g:
  - req_ready[g] = ~wfull.
  - winc = req_valid[g] & ~wfull.
  - wdata = req_data[g].
  - All other req_ready bits are 0.
- Beat counting: on each beat (winc = 1), beat_cnt increments.
- Release: on a beat where req_last[g] = 1 or beat_cnt == MAX_BURST-1:
  - last_grant <= g; beat_cnt <= 0; grant_active <= 0; state goes to IDLE.
  - The release is registered; there is exactly one bubble cycle before the next grant.
- Grant hold: in BUSY with req_valid[g] = 0, the grant is held (packet lock). No timeout; other requesters wait.
- wfull: while wfull = 1, winc = 0 and req_ready = 0. Hold the grant and beat_cnt unchanged.
- Data: wdata is a pure mux of req_data; nothing is stored.
- Outputs outside BUSY: winc and all req_ready are 0. grant_id holds its last value.
- Wrap-around:
  - The round-robin search wraps from NUM_REQ-1 to 0.
  - The beat counter width is $clog2(MAX_BURST+1).
- MAX_BURST = 1: every beat releases the grant.
- Reset mid-packet: the transfer is abandoned and the FSM returns to IDLE. The FIFO keeps already-written words; packet integrity is the requester's responsibility.
- Invariants (assertion targets):
  - winc implies ~wfull.
  - At most one req_ready bit is high.
  - winc == |(req_valid & req_ready).

Decomposition:
- Package async_fifo_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - Helper function for index width ($clog2 with minimum 1).
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector and last index.
  - Outputs: found flag and selected index.
  - Implementation: double-width vector with masked priority encode.

Test Plan:
- Single requester (NUM_REQ=4): after reset, req_valid=4'b0001 with a 3-word packet 0xA1,0xA2,0xA3 (last on 0xA3).
  - Grant on cycle 1; winc on cycles 2-4 with wdata A1..A3; grant_active drops on cycle 5.
- Round-robin: all four valid, each sending 1-word packets with last=1.
  - Grant order 0,1,2,3,0.
  - One write every 2 cycles.
- Burst limit (MAX_BURST=8): requester 2 streams 20 words without last while requester 0 is also valid.
  - Requester 2 is released after 8 beats, then requester 0 is granted.
  - grant_id sequence 2,0.
- Backpressure: wfull=1 for 3 cycles mid-packet.
  - winc=0 and req_ready[g]=0 during the stall.
  - No words lost or duplicated; beat_cnt holds.
- Grant hold: granted requester deasserts valid for 4 cycles mid-packet while others are valid.
  - Grant holds with no winc.
  - Packet resumes and completes before any other grant.
- Reset mid-packet: assert wrst asynchronously between clock edges during beat 2.
  - All outputs go to 0 immediately.
  - After release, requester 0 wins first if valid.
